// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and
// offers one instruction at a time downstream until STOP is consumed.
module fetch_stage #(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = 16,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               halted
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    localparam logic [1:0] HALT  = 2'd3;

    localparam logic [3:0]        OP_STOP  = 4'hF;
    localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        // Redirect outranks ack, stall and STOP in every live state; an ack
        // landing in the same cycle is simply dropped with the request.
        if (state_q != HALT && redirect) begin
            pc_d    = redirect_pc;
            state_d = FETCH;
        end else begin
            case (state_q)
                IDLE:  state_d = FETCH;
                FETCH: if (imem_ack) begin
                    instr_d    = imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 1'b1;
                    state_d    = ISSUE;
                end
                ISSUE: if (!stall) begin
                    state_d = (instr_q[INSTR_W-1 -: 4] == OP_STOP) ? HALT : FETCH;
                end
                default: state_d = HALT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= PC_RESET;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Outputs decode registered state only, so reset drops imem_req at once.
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[INSTR_W-1 -: 4];
    assign instr_pc    = instr_pc_q;
    assign instr_valid = (state_q == ISSUE);
    assign halted      = (state_q == HALT);

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the 4-bit-opcode, 16-bit-instruction datapath. Holds the program counter and requests instructions from instruction memory with a req/ack handshake. Presents the fetched instruction, its opcode field and its PC to the decode/control stage. Accepts branch/jump redirects from execute and halts after the STOP instruction (opcode 4'b1111) is consumed.

## Interface

Parameters:
- ADDR_W, 8, width of PC and instruction memory address.
- INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1:INSTR_W-4].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request; address valid while high.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_ack  in  1  memory response; imem_rdata valid in the same cycle.
- imem_rdata  in  INSTR_W  fetched instruction.
- stall  in  1  downstream cannot consume the presented instruction.
- redirect  in  1  branch/jump taken; load redirect_pc.
- redirect_pc  in  ADDR_W  new PC target.
- instr  out  INSTR_W  instruction register.
- opcode  out  4  instr[INSTR_W-1:INSTR_W-4], feeds control unit.
- instr_pc  out  ADDR_W  PC of instr.
- instr_valid  out  1  instr is valid and offered downstream.
- halted  out  1  STOP consumed; fetch stopped.

## Operation

- States: IDLE, FETCH, ISSUE, HALT. Reset enters IDLE.
- IDLE: no request; next cycle -> FETCH.
- FETCH: imem_req=1, imem_addr=pc, held stable until imem_ack. On imem_ack: instr<=imem_rdata, instr_pc<=pc, pc<=pc+1 (mod 2^ADDR_W, wraps max->0), -> ISSUE.
- ISSUE: instr_valid=1, imem_req=0. If stall=1, hold instr/instr_pc/pc unchanged. If stall=0, instruction consumed this cycle: opcode==4'b1111 -> HALT, else -> FETCH.
- HALT: halted=1, instr_valid=0, imem_req=0. Only reset exits HALT.
- Redirect (IDLE, FETCH, ISSUE): highest priority over ack, stall and STOP. pc<=redirect_pc, -> FETCH, instr_valid drops next cycle. imem_ack arriving in the same cycle is discarded (instr unchanged). The memory contract allows a request to be abandoned by dropping imem_req.
- Redirect in HALT: ignored.
- Redirect in ISSUE with stall=1: still taken; the held instruction is flushed.
- Reset mid-fetch: an outstanding request is abandoned immediately (imem_req=0 asynchronously).

## Timing

- Reset values: pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, imem_req=0, imem_addr=RESET_PC, state=IDLE.
- All outputs are registered or decoded from state/registers only. There is no combinational path from any input to any output.
- First request is asserted in the 2nd cycle after reset deasserts: IDLE 1 cycle, then FETCH.
- Fetch latency: imem_ack in cycle n -> instr_valid=1 in cycle n+1.
- Throughput: one instruction per 2 cycles minimum (FETCH + ISSUE) with a zero-wait memory. Each stall cycle adds one cycle.
- Redirect in cycle n: imem_req=1 with imem_addr=redirect_pc in cycle n+1.
- STOP consumed (ISSUE, stall=0) in cycle n: halted=1 from cycle n+1.

## Test plan

- Reset, zero-wait memory returning opcodes 0,1,2 at addresses 0..2:
  - imem_req rises 2 cycles after reset release; addr 0,1,2 in sequence.
  - instr_valid pulses every 2nd cycle with instr_pc 0,1,2.
- Memory with 3-cycle ack delay:
  - imem_addr stays constant and imem_req stays high for 3 cycles.
  - instr_valid follows the ack by 1 cycle.
  - pc increments exactly once per fetch.
- stall=1 for 4 cycles while ISSUE holds instr 16'h2345:
  - instr, instr_pc and instr_valid stay stable.
  - No imem_req during the stall.
  - Next fetch starts the cycle after stall drops.
- redirect=1, redirect_pc=8'h40 in the same cycle as imem_ack:
  - The acked data is discarded and instr is unchanged.
  - Next cycle imem_req=1 with imem_addr=8'h40.
- Fetch at pc=8'hFF: next fetch address is 8'h00.
- STOP (16'hF000) fetched:
  - Held for 2 cycles of stall, then consumed; halted=1 next cycle.
  - After that, imem_req stays 0 and redirect is ignored.
  - Reset returns to IDLE with halted=0.
